mips_mem_access_unit: RTL

- Load/store initiator between the MIPS datapath and the word-indexed data memory. Each memory location holds one 32-bit word; byte and halfword stores update only the low bits of that word.
- Accepts one load or store request per transaction over a valid/ready handshake and drives the memory's read/write strobes, address, write data and opcode.
- For loads, captures the memory's registered read data and applies byte/halfword extraction with sign or zero extension. Returns the result over a valid/ready response channel.

---
 rtl/mips_mem_access_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mips_mem_access_unit.sv
// Load/store initiator between the MIPS datapath and a word-indexed data memory.
// Define MEM_ACCESS_BOUNDS_CHECK_EN to reject addresses >= MEM_DEPTH; otherwise they wrap modulo MEM_DEPTH.
module mips_mem_access_unit #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       write_data,
  output logic [5:0]        opCode,
  output logic              sig_mem_read,
  output logic              sig_mem_write,
  input  logic [31:0]       read_data
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_ISSUE,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [5:0]          op_q, op_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic                req_is_load, req_is_store, range_err;
  logic [ADDR_W-1:0]   req_addr_eff;
  logic [31:0]         load_ext;

  assign req_is_load  = (req_opcode == OP_LB) || (req_opcode == OP_LH) || (req_opcode == OP_LW) ||
                        (req_opcode == OP_LBU) || (req_opcode == OP_LHU);
  assign req_is_store = (req_opcode == OP_SB) || (req_opcode == OP_SH) || (req_opcode == OP_SW);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  assign range_err    = (req_addr >= ADDR_W'(MEM_DEPTH));
  assign req_addr_eff = req_addr;
`else
  assign range_err    = 1'b0;
  assign req_addr_eff = req_addr % ADDR_W'(MEM_DEPTH);
`endif

  // Extension is keyed off the latched opcode, so it only depends on registered state plus read_data.
  always_comb begin
    load_ext = read_data;
    case (op_q)
      OP_LB:   load_ext = {{24{read_data[7]}}, read_data[7:0]};
      OP_LBU:  load_ext = {24'h0, read_data[7:0]};
      OP_LH:   load_ext = {{16{read_data[15]}}, read_data[15:0]};
      OP_LHU:  load_ext = {16'h0, read_data[15:0]};
      default: load_ext = read_data;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr_eff;
          wdata_d    = req_wdata;
          op_d       = req_opcode;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          if ((!req_is_load && !req_is_store) || range_err) begin
            rsp_err_d = 1'b1;
            state_d   = RESP;
          end else if (req_is_load) begin
            state_d = RD_ISSUE;
          end else begin
            state_d = WR_ISSUE;
          end
        end
      end
      RD_ISSUE:   state_d = RD_CAPTURE;
      RD_CAPTURE: begin
        rsp_data_d = load_ext;
        state_d    = RESP;
      end
      WR_ISSUE: begin
        rsp_data_d = '0;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_err_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign sig_mem_read  = (state_q == RD_ISSUE);
  assign sig_mem_write = (state_q == WR_ISSUE);
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign mem_address   = addr_q;
  assign write_data    = wdata_q;
  assign opCode        = op_q;

endmodule
